// File: rtl/neuron_pkg.sv
// Shared types and constants for the neuron sequencing controller.
// Holds the FSM encoding, default sizes and the offset-width helper.
package neuron_pkg;

    localparam int DEFAULT_N  = 10;
    localparam int DEFAULT_DW = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ACCUM = 3'd2,
        FINAL = 3'd3,
        HOLD  = 3'd4
    } state_t;

    // Width needed to address offsets 0..n-1, never narrower than one bit.
    function automatic int offset_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/neuron_offset_counter.sv
// Input/weight offset counter: steps 0..N-1 while enabled, wrapping to 0 after the last offset.
// The last flag lets the sequencer leave the accumulate phase on the final offset.
module neuron_offset_counter
    import neuron_pkg::*;
#(
    parameter  int N  = DEFAULT_N,
    localparam int OW = offset_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [OW-1:0] count,
    output logic          last
);

    assign last = (count == OW'(N - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= last ? '0 : count + OW'(1);
        end
    end

endmodule

// File: rtl/neuron_controller.sv
// Sequencer that drives one neuron datapath through clear, accumulate and activate,
// then offers the captured result to the next layer over a valid/accept handshake.
module neuron_controller
    import neuron_pkg::*;
#(
    parameter  int N  = DEFAULT_N,
    parameter  int DW = DEFAULT_DW,
    localparam int OW = offset_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          hidden_in,
    output logic          acc_clr,
    output logic          ld,
    output logic [OW-1:0] offset,
    output logic          ready,
    output logic          hidden,
    input  logic [DW-1:0] result_in,
    output logic [DW-1:0] result_out,
    output logic          result_valid,
    input  logic          result_accept,
    output logic          busy
);

    state_t        state_q;
    state_t        state_d;
    logic [OW-1:0] count;
    logic          last;
    logic          take_start;

    neuron_offset_counter #(.N(N)) u_offset_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (state_q == CLEAR),
        .en    (state_q == ACCUM),
        .count (count),
        .last  (last)
    );

    // A new evaluation is accepted from IDLE, or on the HOLD cycle that hands off the old result.
    assign take_start = start && ((state_q == IDLE) || ((state_q == HOLD) && result_accept));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = CLEAR;
            CLEAR:   state_d = ACCUM;
            ACCUM:   if (last) state_d = FINAL;
            FINAL:   state_d = HOLD;
            HOLD:    if (result_accept) state_d = start ? CLEAR : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes decode the registered state only; acc_clr also follows rst so the datapath clears during reset.
    always_comb begin
        acc_clr = rst || (state_q == CLEAR);
        ld      = (state_q == ACCUM);
        ready   = (state_q == FINAL);
        offset  = (state_q == ACCUM) ? count : '0;
        busy    = (state_q != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hidden       <= 1'b0;
            result_out   <= '0;
            result_valid <= 1'b0;
        end else begin
            if (take_start) begin
                hidden <= hidden_in;
            end
            if (state_q == FINAL) begin
                result_out   <= result_in;
                result_valid <= 1'b1;
            end else if ((state_q == HOLD) && result_accept) begin
                result_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_neuron_controller.sv
// Directed bench: two controllers (N=10 and N=2) each paired with a behavioural
// multiply-accumulate datapath; expected results are hand-computed constants.
module tb_neuron_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       a_start, a_hidden_in, a_acc_clr, a_ld, a_ready, a_hidden;
    logic       a_result_valid, a_result_accept, a_busy;
    logic [3:0] a_offset;
    logic [7:0] a_result_in, a_result_out;

    logic       b_start, b_hidden_in, b_acc_clr, b_ld, b_ready, b_hidden;
    logic       b_result_valid, b_result_accept, b_busy;
    logic [0:0] b_offset;
    logic [7:0] b_result_in, b_result_out;

    int n_checks = 0;
    int n_fail   = 0;

    neuron_controller #(.N(10), .DW(8)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .hidden_in(a_hidden_in),
        .acc_clr(a_acc_clr), .ld(a_ld), .offset(a_offset), .ready(a_ready),
        .hidden(a_hidden), .result_in(a_result_in), .result_out(a_result_out),
        .result_valid(a_result_valid), .result_accept(a_result_accept), .busy(a_busy)
    );

    neuron_controller #(.N(2), .DW(8)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .hidden_in(b_hidden_in),
        .acc_clr(b_acc_clr), .ld(b_ld), .offset(b_offset), .ready(b_ready),
        .hidden(b_hidden), .result_in(b_result_in), .result_out(b_result_out),
        .result_valid(b_result_valid), .result_accept(b_result_accept), .busy(b_busy)
    );

    // Hidden layers saturate at 255; output layers keep the low byte.
    function automatic logic [7:0] act(input int s, input logic h);
        if (h && s > 255) return 8'd255;
        return 8'(s);
    endfunction

    // Datapath A: inp[i] = i+1, every weight = a_wgt.
    int a_wgt = 2;
    int a_acc = 0;
    always @(posedge clk) begin
        if (a_acc_clr)  a_acc <= 0;
        else if (a_ld)  a_acc <= a_acc + (int'(a_offset) + 1) * a_wgt;
    end
    always_comb a_result_in = a_ready ? act(a_acc, a_hidden) : 8'h00;

    // Datapath B: inp = {5,7}, w = {3,4}.
    int b_inp [2] = '{5, 7};
    int b_w   [2] = '{3, 4};
    int b_acc = 0;
    always @(posedge clk) begin
        if (b_acc_clr)  b_acc <= 0;
        else if (b_ld)  b_acc <= b_acc + b_inp[b_offset] * b_w[b_offset];
    end
    always_comb b_result_in = b_ready ? act(b_acc, b_hidden) : 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the edge that samples start.
    task automatic a_start_eval(input logic h);
        a_start     = 1'b1;
        a_hidden_in = h;
        step();
        a_start     = 1'b0;
        a_hidden_in = ~h;
    endtask

    // Follows one evaluation from the CLEAR cycle to the first HOLD cycle.
    task automatic a_run(input string tag, input logic h, input logic [7:0] exp, input int inject_at);
        check({tag, ".clr"},    a_acc_clr,      1);
        check({tag, ".clr_ld"}, a_ld,           0);
        check({tag, ".busy"},   a_busy,         1);
        check({tag, ".vld0"},   a_result_valid, 0);
        check({tag, ".hid0"},   a_hidden,       h);
        for (int j = 1; j <= 10; j++) begin
            step();
            a_start = 1'b0;
            check($sformatf("%s.ld%0d", tag, j - 1),  a_ld,      1);
            check($sformatf("%s.off%0d", tag, j - 1), a_offset,  j - 1);
            check($sformatf("%s.aclr%0d", tag, j - 1), a_acc_clr, 0);
            check($sformatf("%s.rdy%0d", tag, j - 1), a_ready,   0);
            check($sformatf("%s.hid%0d", tag, j - 1), a_hidden,  h);
            if (j - 1 == inject_at) begin
                a_start     = 1'b1;
                a_hidden_in = ~h;
            end
        end
        step();
        check({tag, ".fin_rdy"}, a_ready,        1);
        check({tag, ".fin_ld"},  a_ld,           0);
        check({tag, ".fin_off"}, a_offset,       0);
        check({tag, ".fin_vld"}, a_result_valid, 0);
        step();
        check({tag, ".vld"},  a_result_valid, 1);
        check({tag, ".res"},  a_result_out,   exp);
        check({tag, ".rdy"},  a_ready,        0);
        check({tag, ".hbsy"}, a_busy,         1);
        check({tag, ".hid"},  a_hidden,       h);
    endtask

    task automatic a_accept_to_idle(input string tag);
        a_result_accept = 1'b1;
        step();
        a_result_accept = 1'b0;
        check({tag, ".idle_busy"}, a_busy,         0);
        check({tag, ".idle_vld"},  a_result_valid, 0);
    endtask

    initial begin
        rst = 1'b1;
        a_start = 0; a_hidden_in = 0; a_result_accept = 0;
        b_start = 0; b_hidden_in = 0; b_result_accept = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        check("rst.acc_clr", a_acc_clr,      1);
        check("rst.busy",    a_busy,         0);
        check("rst.ld",      a_ld,           0);
        check("rst.ready",   a_ready,        0);
        check("rst.offset",  a_offset,       0);
        check("rst.valid",   a_result_valid, 0);
        check("rst.result",  a_result_out,   0);
        check("rst.hidden",  a_hidden,       0);
        check("rst.b_busy",  b_busy,         0);
        rst = 1'b0;
        step();
        check("idle.acc_clr", a_acc_clr, 0);
        check("idle.busy",    a_busy,    0);

        // Basic run: sum (1..10)*2 = 110, hidden layer.
        a_wgt = 2;
        a_start_eval(1'b1);
        a_run("basic", 1'b1, 8'd110, -1);

        // Backpressure: result held for 20 cycles without accept.
        for (int k = 0; k < 20; k++) begin
            step();
            check($sformatf("bp.vld%0d", k), a_result_valid, 1);
            check($sformatf("bp.res%0d", k), a_result_out,   110);
            check($sformatf("bp.hid%0d", k), a_hidden,       1);
        end
        a_accept_to_idle("bp");

        // Back-to-back: 3*55 = 165, then 10*55 = 550 -> low byte 38 on an output layer.
        a_wgt = 3;
        a_start_eval(1'b1);
        a_run("b2b_a", 1'b1, 8'd165, -1);
        a_result_accept = 1'b1;
        a_start         = 1'b1;
        a_hidden_in     = 1'b0;
        a_wgt           = 10;
        step();
        a_result_accept = 1'b0;
        a_start         = 1'b0;
        a_hidden_in     = 1'b1;
        a_run("b2b_b", 1'b0, 8'd38, -1);
        a_accept_to_idle("b2b");

        // Start during ACCUM at offset 4 is ignored.
        a_wgt = 2;
        a_start_eval(1'b1);
        a_run("ign", 1'b1, 8'd110, 4);
        a_accept_to_idle("ign");
        for (int k = 0; k < 15; k++) begin
            step();
            check($sformatf("ign.quiet_busy%0d", k), a_busy,         0);
            check($sformatf("ign.quiet_vld%0d", k),  a_result_valid, 0);
        end

        // Reset at offset 6, then a full evaluation: 1*55 = 55.
        a_wgt = 1;
        a_start_eval(1'b0);
        for (int j = 1; j <= 7; j++) step();
        check("mid.off6", a_offset, 6);
        rst = 1'b1;
        #1;
        check("mid.acc_clr_comb", a_acc_clr, 1);
        @(negedge clk);
        check("mid.busy",    a_busy,         0);
        check("mid.ld",      a_ld,           0);
        check("mid.offset",  a_offset,       0);
        check("mid.valid",   a_result_valid, 0);
        check("mid.acc_clr", a_acc_clr,      1);
        rst = 1'b0;
        #1;
        check("mid.acc_clr_rel", a_acc_clr, 0);
        @(negedge clk);
        a_start_eval(1'b0);
        a_run("post_rst", 1'b0, 8'd55, -1);
        a_accept_to_idle("post_rst");

        // N=2: 5*3 + 7*4 = 43, valid at edge 4 after start.
        b_start     = 1'b1;
        b_hidden_in = 1'b1;
        step();
        b_start = 1'b0;
        check("n2.clr",    b_acc_clr, 1);
        check("n2.clr_ld", b_ld,      0);
        for (int j = 1; j <= 2; j++) begin
            step();
            check($sformatf("n2.ld%0d", j - 1),  b_ld,     1);
            check($sformatf("n2.off%0d", j - 1), b_offset, j - 1);
        end
        step();
        check("n2.rdy",     b_ready,        1);
        check("n2.fin_ld",  b_ld,           0);
        check("n2.fin_vld", b_result_valid, 0);
        step();
        check("n2.vld",    b_result_valid, 1);
        check("n2.res",    b_result_out,   43);
        check("n2.hidden", b_hidden,       1);
        b_result_accept = 1'b1;
        step();
        b_result_accept = 1'b0;
        check("n2.idle", b_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/neuron_controller.md
Name: neuron_controller

Overview:
- Sequencing FSM that drives one neuron datapath through a complete evaluation.
- Accepts a start request, then runs the datapath's control side:
  - clears the accumulator,
  - steps the input/weight offset 0..N-1 with load asserted,
  - asserts ready so the activation stage evaluates,
  - captures the DW-bit neuron result.
- Hands the result to the next layer over a valid/accept handshake.
- The datapath is the responder; this block is its initiator.

Parameters:
- N, 10, inputs per neuron; legal range N >= 2.
- DW, 8, result width in bits.
- OW, $clog2(N), offset width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request one neuron evaluation; sampled only in IDLE or on the HOLD accept cycle
- hidden_in  input  1  layer type for this evaluation; captured with start
- acc_clr  output  1  accumulator clear to datapath
- ld  output  1  accumulate enable to datapath
- offset  output  OW  input/weight select to datapath
- ready  output  1  activation evaluate strobe to datapath
- hidden  output  1  registered layer type to datapath; held for the whole evaluation
- result_in  input  DW  activation output from datapath
- result_out  output  DW  captured neuron result
- result_valid  output  1  result_out valid
- result_accept  input  1  consumer takes result_out
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst=1 at a clk edge):
  - state goes to IDLE; counter, hidden, result_out and result_valid go to 0.
  - acc_clr = rst OR (state==CLEAR), so it is combinationally high during reset.
  - ld, ready and offset are 0.
  - Reset mid-operation abandons the evaluation; no partial result is ever flagged valid.
- IDLE: busy=0, all strobes 0. start=1 latches hidden_in into hidden, then goes to CLEAR.
- CLEAR (1 cycle): acc_clr=1, offset=0, ld=0. Counter cleared; then ACCUM.
- ACCUM (exactly N cycles):
  - ld=1 and offset=counter; counter increments each cycle.
  - When counter==N-1, counter returns to 0 and the state goes to FINAL.
  - Offset never exceeds N-1.
- FINAL (1 cycle):
  - ready=1, ld=0, offset=0.
  - result_in is registered into result_out at the end of this cycle; result_valid becomes 1; then HOLD.
- HOLD:
  - result_valid=1; result_out and hidden stay stable.
  - Without result_accept: remain in HOLD indefinitely.
  - result_accept=1 and start=0: result_valid falls next cycle; go to IDLE.
  - result_accept=1 and start=1 on the same cycle: back-to-back; go directly to CLEAR, latch the new hidden_in, and drop result_valid.
- start while busy (other than the HOLD accept cycle) is ignored. No queuing.
- result_accept outside HOLD is ignored.
- Latency: start sampled at edge 0 puts result_valid high at edge N+2. Throughput is one result per N+3 cycles with an always-accepting consumer.
- Strobes are registered decodes of state, except acc_clr's reset term. No combinational path from result_accept or start to any output.

Decomposition:
- Package neuron_pkg:
  - state encoding (IDLE, CLEAR, ACCUM, FINAL, HOLD) as a typedef;
  - default N and DW constants;
  - an offset-width function (clog2 of N).
- One natural sub-module: neuron_offset_counter.
  - Parameterised by N.
  - Inputs: clk, rst, clr, en.
  - Outputs: count, last (count==N-1).
  - Wraps to 0 on en while last.
- The FSM and handshake stay in neuron_controller.
- The bench pairs the controller with a behavioural datapath model (accumulates inp[offset]*w[offset] on ld; produces result on ready).

Test Plan:
- Basic run, N=10:
  - stimulus: rst for 2 cycles; pulse start with hidden_in=1; hold result_accept=0.
  - response: acc_clr high for 1 cycle; ld high for exactly 10 cycles with offset 0,1,...,9; ready for 1 cycle; result_valid rises at edge 12 after start; result_out equals the model result; hidden=1 throughout.
- Backpressure:
  - stimulus: hold result_accept=0 for 20 cycles after valid; then pulse it.
  - response: result_valid and result_out stable for all 20 cycles; IDLE and busy=0 on the cycle after accept.
- Back-to-back:
  - stimulus: result_accept=1 and start=1 on the same HOLD cycle, with hidden_in=0.
  - response: next cycle is CLEAR with acc_clr=1; hidden=0; second result valid 12 cycles later; no idle gap.
- Ignored start:
  - stimulus: pulse start during ACCUM at offset=4.
  - response: offset sequence continues 5..9 unaltered; exactly one result produced.
- Reset mid-operation:
  - stimulus: assert rst during ACCUM at offset=6.
  - response: next edge gives busy=0, ld=0, offset=0, result_valid=0; acc_clr high while rst=1; a subsequent start produces the full sequence from offset 0.
- Minimum size, N=2 (OW=1):
  - stimulus: start.
  - response: ld for exactly 2 cycles (offset 0,1); result_valid at edge 4 after start.
